// File: rtl/mx_acc_pkg.sv
// Shared definitions for the multi-channel MX accumulator.
// Contents:
//   MX_BIAS / MX_M_W  default exponent bias and mantissa width
//   MX_EXP_MIN/MAX    clamp limits for biased exponents of non-zero values
//   mx_fp_t           sign / biased exponent / unsigned mantissa triple
//   acc_state_e       frame control states
package mx_acc_pkg;

  localparam int         MX_BIAS    = 127;
  localparam int         MX_M_W     = 23;
  localparam logic [7:0] MX_EXP_MIN = 8'd1;
  localparam logic [7:0] MX_EXP_MAX = 8'd255;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MX_M_W-1:0] mant;
  } mx_fp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mx_fp_acc_lane.sv
// One accumulation channel: rescales a partial product by the two shared
// block exponents and adds it to the current accumulator (sign-magnitude,
// truncating alignment, carry handling and left normalisation).
// Purely combinational; the caller registers the result.
// Ports:
//   acc_sign_i/acc_exp_i/acc_mant_i  current accumulator value
//   p_sign_i/p_exp_i/p_mant_i        partial product (biased exponent)
//   sh_exp0_i/sh_exp1_i              shared block exponents (biased)
//   res_sign_o/res_exp_o/res_mant_o  accumulator after adding the product
module mx_fp_acc_lane
  import mx_acc_pkg::*;
#(
  parameter int M_W  = MX_M_W,
  parameter int BIAS = MX_BIAS
) (
  input  logic           acc_sign_i,
  input  logic [7:0]     acc_exp_i,
  input  logic [M_W-1:0] acc_mant_i,
  input  logic           p_sign_i,
  input  logic [7:0]     p_exp_i,
  input  logic [M_W-1:0] p_mant_i,
  input  logic [7:0]     sh_exp0_i,
  input  logic [7:0]     sh_exp1_i,
  output logic           res_sign_o,
  output logic [7:0]     res_exp_o,
  output logic [M_W-1:0] res_mant_o
);

  localparam logic signed [11:0] BIAS2 = 12'(2 * BIAS);
  localparam logic [7:0]         M_W_E = 8'(M_W);

  // Saturate the rescaled exponent into the representable non-zero range.
  function automatic logic [7:0] clamp_exp(input logic signed [11:0] e);
    logic [7:0] r;
    if (e < $signed({4'b0000, MX_EXP_MIN}))      r = MX_EXP_MIN;
    else if (e > $signed({4'b0000, MX_EXP_MAX})) r = MX_EXP_MAX;
    else                                         r = e[7:0];
    return r;
  endfunction

  // Shift left until the MSB is set, stopping early once the exponent
  // reaches its floor. Returns {exp, mant}.
  function automatic logic [M_W+7:0] norm_left(input logic [M_W-1:0] m,
                                               input logic [7:0]     e);
    logic [M_W-1:0] mm;
    logic [7:0]     ee;
    mm = m;
    ee = e;
    for (int i = 0; i < M_W; i++) begin
      if (!mm[M_W-1] && (ee > MX_EXP_MIN)) begin
        mm = mm << 1;
        ee = ee - 8'd1;
      end
    end
    return {ee, mm};
  endfunction

  logic signed [11:0] e_raw;
  logic [7:0]         p_exp_eff;
  logic               big_s, sml_s;
  logic [7:0]         big_e, sml_e, d;
  logic [M_W-1:0]     big_m, sml_m, sml_sh, diff;
  logic [M_W:0]       sum;

  always_comb begin
    // 12-bit intermediate: the three-way sum reaches 765 before the bias
    // is removed.
    e_raw = $signed({4'b0000, sh_exp0_i}) + $signed({4'b0000, sh_exp1_i})
          + $signed({4'b0000, p_exp_i}) - BIAS2;
    p_exp_eff = clamp_exp(e_raw);

    res_sign_o = acc_sign_i;
    res_exp_o  = acc_exp_i;
    res_mant_o = acc_mant_i;
    sum        = '0;
    diff       = '0;

    // Order operands so "big" carries the larger (or equal) exponent.
    if (acc_exp_i >= p_exp_eff) begin
      big_s = acc_sign_i; big_e = acc_exp_i; big_m = acc_mant_i;
      sml_s = p_sign_i;   sml_e = p_exp_eff; sml_m = p_mant_i;
    end else begin
      big_s = p_sign_i;   big_e = p_exp_eff; big_m = p_mant_i;
      sml_s = acc_sign_i; sml_e = acc_exp_i; sml_m = acc_mant_i;
    end
    d      = big_e - sml_e;
    sml_sh = (d >= M_W_E) ? '0 : (sml_m >> d);

    if (p_mant_i == '0) begin
      // zero product: accumulator passes through unchanged
    end else if (acc_mant_i == '0) begin
      res_sign_o              = p_sign_i;
      {res_exp_o, res_mant_o} = norm_left(p_mant_i, p_exp_eff);
    end else if (big_s == sml_s) begin
      sum        = {1'b0, big_m} + {1'b0, sml_sh};
      res_sign_o = big_s;
      if (sum[M_W]) begin
        if (big_e == MX_EXP_MAX) begin
          res_exp_o  = MX_EXP_MAX;
          res_mant_o = '1;
        end else begin
          res_exp_o  = big_e + 8'd1;
          res_mant_o = sum[M_W:1];
        end
      end else begin
        res_exp_o  = big_e;
        res_mant_o = sum[M_W-1:0];
      end
    end else begin
      if (big_m >= sml_sh) begin
        diff       = big_m - sml_sh;
        res_sign_o = big_s;
      end else begin
        diff       = sml_sh - big_m;
        res_sign_o = sml_s;
      end
      if (diff == '0) begin
        res_sign_o = 1'b0;
        res_exp_o  = 8'd0;
        res_mant_o = '0;
      end else begin
        {res_exp_o, res_mant_o} = norm_left(diff, big_e);
      end
    end
  end

endmodule

// File: rtl/mx_mac_acc_array.sv
// Multi-channel MX accumulator placed after the MX multiplier array.
// Each accepted beat adds NUM_CH rescaled partial products into per-channel
// accumulators; after acc_len beats the results are offered through a
// valid/ready handshake.
// Ports:
//   clk_i, rstn              clock, asynchronous active-low reset
//   clear_i                  synchronous abort to IDLE with zeroed accumulators
//   start_i, acc_len_i       frame start and frame length (0 means 1)
//   in_valid_i, in_ready_o   input beat handshake
//   p_mant_i/p_exp_i/p_sign_i  per-channel products, channel c in slice c
//   sh_exp0_i, sh_exp1_i     shared block exponents
//   out_valid_o, out_ready_i result handshake
//   acc_mant_o/acc_exp_o/acc_sign_o  per-channel accumulated results
module mx_mac_acc_array
  import mx_acc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int M_W    = MX_M_W,
  parameter int LEN_W  = 8,
  parameter int BIAS   = MX_BIAS
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      acc_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NUM_CH*M_W-1:0] p_mant_i,
  input  logic [NUM_CH*8-1:0]   p_exp_i,
  input  logic [NUM_CH-1:0]     p_sign_i,
  input  logic [7:0]            sh_exp0_i,
  input  logic [7:0]            sh_exp1_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NUM_CH*M_W-1:0] acc_mant_o,
  output logic [NUM_CH*8-1:0]   acc_exp_o,
  output logic [NUM_CH-1:0]     acc_sign_o
);

  acc_state_e                 state_q;
  logic [LEN_W-1:0]           cnt_q;
  logic                       in_ready_q, out_valid_q;
  logic [NUM_CH-1:0][M_W-1:0] acc_mant_q, acc_mant_d;
  logic [NUM_CH-1:0][7:0]     acc_exp_q, acc_exp_d;
  logic [NUM_CH-1:0]          acc_sign_q, acc_sign_d;
  logic [LEN_W-1:0]           len_eff;
  logic                       beat_acc;

  assign len_eff  = (acc_len_i == '0) ? LEN_W'(1) : acc_len_i;
  assign beat_acc = in_valid_i & in_ready_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    mx_fp_acc_lane #(
      .M_W  (M_W),
      .BIAS (BIAS)
    ) u_lane (
      .acc_sign_i (acc_sign_q[c]),
      .acc_exp_i  (acc_exp_q[c]),
      .acc_mant_i (acc_mant_q[c]),
      .p_sign_i   (p_sign_i[c]),
      .p_exp_i    (p_exp_i[c*8 +: 8]),
      .p_mant_i   (p_mant_i[c*M_W +: M_W]),
      .sh_exp0_i  (sh_exp0_i),
      .sh_exp1_i  (sh_exp1_i),
      .res_sign_o (acc_sign_d[c]),
      .res_exp_o  (acc_exp_d[c]),
      .res_mant_o (acc_mant_d[c])
    );
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_mant_q  <= '0;
      acc_exp_q   <= '0;
      acc_sign_q  <= '0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_mant_q  <= '0;
      acc_exp_q   <= '0;
      acc_sign_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= ACCUM;
            cnt_q      <= len_eff;
            in_ready_q <= 1'b1;
            acc_mant_q <= '0;
            acc_exp_q  <= '0;
            acc_sign_q <= '0;
          end
        end
        ACCUM: begin
          if (beat_acc) begin
            acc_mant_q <= acc_mant_d;
            acc_exp_q  <= acc_exp_d;
            acc_sign_q <= acc_sign_d;
            cnt_q      <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Results stay frozen until consumed; a start in the consuming
          // cycle opens the next frame without an IDLE bubble.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (start_i) begin
              state_q    <= ACCUM;
              cnt_q      <= len_eff;
              in_ready_q <= 1'b1;
              acc_mant_q <= '0;
              acc_exp_q  <= '0;
              acc_sign_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign acc_mant_o  = acc_mant_q;
  assign acc_exp_o   = acc_exp_q;
  assign acc_sign_o  = acc_sign_q;

endmodule
